// File: rtl/apb_timer_initiator.sv
// APB3 requester for the timer register file.
// One command in flight; bounded PREADY wait.
module apb_timer_initiator #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_nxt;
  logic                psel_q, psel_d;
  logic                pen_q, pen_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rerr_q, rerr_d;
  logic                rto_q, rto_d;

  assign cnt_nxt = cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    rto_d    = rto_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          if (cmd_addr[1:0] != 2'b00) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
            rto_d    = 1'b0;
            rdata_d  = '0;
          end else begin
            state_d = SETUP;
            psel_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        pen_d   = 1'b1;
      end
      ACCESS: begin
        // A PREADY in the limit cycle still completes the transfer
        if (PREADY) begin
          state_d  = RESP;
          psel_d   = 1'b0;
          pen_d    = 1'b0;
          rvalid_d = 1'b1;
          rerr_d   = PSLVERR;
          rto_d    = 1'b0;
          rdata_d  = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
        end else begin
          cnt_d = cnt_nxt;
          if (TIMEOUT_CYCLES != 0 && cnt_nxt == LIMIT) begin
            state_d  = RESP;
            psel_d   = 1'b0;
            pen_d    = 1'b0;
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
            rto_d    = 1'b1;
            rdata_d  = '0;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      rto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      rto_q    <= rto_d;
    end
  end

  // Held low during reset so every output reads 0 there
  assign cmd_ready   = (state_q == IDLE) && !RST;
  assign PSEL        = psel_q;
  assign PENABLE     = pen_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rvalid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = rerr_q;
  assign rsp_timeout = rto_q;

endmodule

// File: tb/tb_apb_timer_initiator.sv
// Bench for apb_timer_initiator: directed and
// randomized transfers against a rule-based model.
module tb_apb_timer_initiator;

  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int tests = 0;
  int fails = 0;

  apb_timer_initiator #(
    .ADDR_W(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 CLK = ~CLK;

  // One complete command/response exchange. Expected results come from
  // the transfer rules: misaligned -> error without APB, waits >= TO ->
  // timeout, otherwise slave error/data as presented with PREADY.
  task automatic txn(input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input int waits,
                     input logic slverr, input logic [31:0] rdata,
                     input int hold);
    bit          mis;
    logic        exp_err, exp_to;
    logic [31:0] exp_rd;
    int          exp_acc, k;
    mis     = (addr[1:0] != 2'b00);
    exp_to  = !mis && (waits >= TO);
    exp_err = mis || exp_to || slverr;
    exp_rd  = (!mis && !exp_to && !wr && !slverr) ? rdata : 32'h0;
    exp_acc = mis ? 0 : (exp_to ? TO : waits + 1);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL cmd_ready_idle got %b exp 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    PREADY    = 1'b0;
    @(negedge CLK);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    k = 0;
    if (!mis) begin
      tests++;
      if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== addr ||
          PWRITE !== wr || (wr && PWDATA !== wdata)) begin
        fails++;
        $display("FAIL setup sel=%b en=%b addr=%h wr=%b wd=%h exp addr=%h wr=%b wd=%h",
                 PSEL, PENABLE, PADDR, PWRITE, PWDATA, addr, wr, wdata);
      end
      @(negedge CLK);
      while (PSEL === 1'b1 && k < 40) begin
        tests++;
        if (PENABLE !== 1'b1 || PADDR !== addr || PWRITE !== wr) begin
          fails++;
          $display("FAIL access_stable en=%b addr=%h wr=%b exp addr=%h",
                   PENABLE, PADDR, PWRITE, addr);
        end
        PREADY  = (k >= waits);
        PSLVERR = (k >= waits) ? slverr : 1'($urandom);
        PRDATA  = (k >= waits) ? rdata : $urandom;
        k++;
        @(negedge CLK);
      end
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
    end
    tests++;
    if (k != exp_acc) begin
      fails++;
      $display("FAIL access_cycles got %0d exp %0d", k, exp_acc);
    end
    tests++;
    if (rsp_valid !== 1'b1 || PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      fails++;
      $display("FAIL rsp_entry valid=%b sel=%b en=%b", rsp_valid, PSEL, PENABLE);
    end
    tests++;
    if (rsp_err !== exp_err || rsp_timeout !== exp_to ||
        rsp_rdata !== exp_rd) begin
      fails++;
      $display("FAIL rsp_fields err=%b to=%b rd=%h exp err=%b to=%b rd=%h",
               rsp_err, rsp_timeout, rsp_rdata, exp_err, exp_to, exp_rd);
    end
    repeat (hold) begin
      @(negedge CLK);
      tests++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 ||
          rsp_err !== exp_err || rsp_timeout !== exp_to ||
          rsp_rdata !== exp_rd || PSEL !== 1'b0) begin
        fails++;
        $display("FAIL rsp_hold valid=%b rdy=%b err=%b to=%b rd=%h sel=%b",
                 rsp_valid, cmd_ready, rsp_err, rsp_timeout, rsp_rdata, PSEL);
      end
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL rsp_done valid=%b cmd_ready=%b exp 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    tests++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE,
         PWRITE} !== 7'b0 || PADDR !== 32'h0 || PWDATA !== 32'h0 ||
        rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs rdy=%b v=%b sel=%b en=%b addr=%h wd=%h",
               cmd_ready, rsp_valid, PSEL, PENABLE, PADDR, PWDATA);
    end
    RST = 1'b0;
    @(negedge CLK);
    tests++;
    if (cmd_ready !== 1'b1 || PSEL !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release rdy=%b sel=%b v=%b", cmd_ready, PSEL, rsp_valid);
    end
  endtask

  task automatic test_write_zero_wait();
    txn(1'b1, 32'h0C, 32'h80, 0, 1'b0, 32'hDEAD_BEEF, 0);
    tests++;
    if (PADDR !== 32'h0C || PWDATA !== 32'h80 || PWRITE !== 1'b1) begin
      fails++;
      $display("FAIL idle_hold addr=%h wd=%h wr=%b exp 0c/80/1", PADDR, PWDATA, PWRITE);
    end
  endtask

  task automatic test_read_wait();
    txn(1'b0, 32'h08, 32'h0, 3, 1'b0, 32'h1234_5678, 1);
  endtask

  task automatic test_timeout();
    txn(1'b0, 32'h04, 32'h0, 100, 1'b0, 32'h5555_AAAA, 0);
    txn(1'b0, 32'h04, 32'h0, TO - 1, 1'b0, 32'hA5A5_0001, 0);
  endtask

  task automatic test_slverr();
    txn(1'b1, 32'h10, 32'h0000_00FF, 0, 1'b1, 32'h0, 0);
    txn(1'b0, 32'h14, 32'h0, 2, 1'b1, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_misaligned();
    txn(1'b0, 32'h0000_0006, 32'h0, 0, 1'b0, 32'h0, 5);
    txn(1'b1, 32'h0000_0001, 32'h77, 0, 1'b0, 32'h0, 0);
  endtask

  task automatic test_mid_reset();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h10;
    PREADY    = 1'b0;
    @(negedge CLK);
    cmd_valid = 1'b0;
    repeat (2) @(negedge CLK);
    tests++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
      fails++;
      $display("FAIL mid_access sel=%b en=%b exp 1/1", PSEL, PENABLE);
    end
    RST = 1'b1;
    @(negedge CLK);
    tests++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset sel=%b en=%b v=%b exp 0", PSEL, PENABLE, rsp_valid);
    end
    RST = 1'b0;
    @(negedge CLK);
    tests++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset rdy=%b v=%b exp 1/0", cmd_ready, rsp_valid);
    end
    txn(1'b0, 32'h18, 32'h0, 1, 1'b0, 32'hCAFE_F00D, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          w;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 4)
                                      : $urandom_range(0, 5);
      txn(1'($urandom), a, $urandom, w,
          ($urandom_range(0, 3) == 0), $urandom,
          $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      txn(i[0], 32'h20 + 32'(i * 4), 32'(i), 0, 1'b0, 32'h100 + 32'(i), 0);
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_slverr();
    test_misaligned();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
